// File: rtl/ppu_vga_sink_if.sv
// rtl/ppu_vga_sink_if.sv - PPU pixel write stream into the VGA sink line banks
interface ppu_vga_sink_if;
  logic [5:0] VGA_STREAM_DATA;
  logic [7:0] PPU_PTR_X;
  logic [7:0] PPU_PTR_Y;
  logic       STREAM_VALID;

  modport master (output VGA_STREAM_DATA, PPU_PTR_X, PPU_PTR_Y, STREAM_VALID);
  modport slave  (input  VGA_STREAM_DATA, PPU_PTR_X, PPU_PTR_Y, STREAM_VALID);
endinterface

// File: rtl/ppu_vga_sink.sv
// rtl/ppu_vga_sink.sv - Double line-buffered PPU to 640x480 VGA sink with underrun flag
module ppu_vga_sink #(
  parameter int         H_TOTAL       = 800,
  parameter int         V_TOTAL       = 525,
  parameter logic [5:0] BORDER_COLOUR = 6'h0F
) (
  input  logic                 PPU_SLOW_CLOCK,
  input  logic                 RST_N,
  ppu_vga_sink_if.slave        stream,
  input  logic                 CLR_ERR,
  output logic                 VGA_HS,
  output logic                 VGA_VS,
  output logic                 VGA_DE,
  output logic [5:0]           VGA_COLOUR,
  output logic [9:0]           VGA_X,
  output logic [9:0]           VGA_Y,
  output logic                 UNDERRUN
);
  localparam logic [9:0] H_LAST = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST = 10'(V_TOTAL - 1);

  logic [5:0]      line_ram [0:511];
  logic [1:0][7:0] tag;
  logic [1:0]      tag_valid;
  logic [9:0]      h, v;
  logic [5:0]      rd_data;
  logic [9:0]      h_q, v_q;
  logic            pix_ok_q, stage_vld_q;

  logic            wr_en, wr_bank, in_image, tag_hit, vis_q;
  logic [7:0]      src_col;

  always_comb begin
    wr_en    = stream.STREAM_VALID && (stream.PPU_PTR_Y < 8'd240);
    wr_bank  = stream.PPU_PTR_Y[0];
    in_image = (h >= 10'd64) && (h < 10'd576) && (v < 10'd480);
    src_col  = 8'((h - 10'd64) >> 1);
    // Source line is v>>1, so its bank is v[1]; tags are compared before this cycle's write.
    tag_hit  = tag_valid[v[1]] && ({1'b0, tag[v[1]]} == v[9:1]);
    vis_q    = (h_q < 10'd640) && (v_q < 10'd480);
  end

  // Line banks are not reset; the non-blocking read returns pre-write data on a collision.
  always_ff @(posedge PPU_SLOW_CLOCK) begin
    if (wr_en)
      line_ram[{wr_bank, stream.PPU_PTR_X}] <= stream.VGA_STREAM_DATA;
    rd_data <= line_ram[{v[1], src_col}];
  end

  always_ff @(posedge PPU_SLOW_CLOCK or negedge RST_N) begin
    if (!RST_N) begin
      h           <= '0;
      v           <= '0;
      tag         <= '0;
      tag_valid   <= '0;
      UNDERRUN    <= 1'b0;
      h_q         <= '0;
      v_q         <= '0;
      pix_ok_q    <= 1'b0;
      stage_vld_q <= 1'b0;
      VGA_HS      <= 1'b1;
      VGA_VS      <= 1'b1;
      VGA_DE      <= 1'b0;
      VGA_COLOUR  <= '0;
      VGA_X       <= '0;
      VGA_Y       <= '0;
    end else begin
      if (h == H_LAST) begin
        h <= '0;
        v <= (v == V_LAST) ? 10'd0 : v + 10'd1;
      end else begin
        h <= h + 10'd1;
      end

      if (wr_en && stream.PPU_PTR_X == 8'd0) begin
        tag[wr_bank]       <= stream.PPU_PTR_Y;
        tag_valid[wr_bank] <= 1'b0;
      end else if (wr_en && stream.PPU_PTR_X == 8'hFF) begin
        tag_valid[wr_bank] <= 1'b1;
      end

      if (in_image && !tag_hit)
        UNDERRUN <= 1'b1;
      else if (CLR_ERR)
        UNDERRUN <= 1'b0;

      h_q         <= h;
      v_q         <= v;
      pix_ok_q    <= in_image && tag_hit;
      stage_vld_q <= 1'b1;

      // Output stage holds reset values until the first counter state reaches it.
      if (stage_vld_q) begin
        VGA_HS     <= !((h_q >= 10'd656) && (h_q <= 10'd751));
        VGA_VS     <= !((v_q >= 10'd490) && (v_q <= 10'd491));
        VGA_DE     <= vis_q;
        VGA_X      <= h_q;
        VGA_Y      <= v_q;
        VGA_COLOUR <= !vis_q ? 6'd0 : (pix_ok_q ? rd_data : BORDER_COLOUR);
      end
    end
  end
endmodule

// File: doc/ppu_vga_sink.md
PPU_VGA_SINK -- requirements
Module: ppu_vga_sink

Interface
REQ-001 Parameter H_TOTAL, default 800, clocks per output line.
REQ-002 Parameter V_TOTAL, default 525, lines per output frame.
REQ-003 Parameter BORDER_COLOUR, default 6'h0F, palette index driven outside the image and on underrun.
REQ-004 PPU_SLOW_CLOCK  in  1  sole clock; all state is updated on its rising edge.
REQ-005 RST_N  in  1  asynchronous reset, active-low.
REQ-006 VGA_STREAM_DATA  in  6  palette index of the pixel being written.
REQ-007 PPU_PTR_X  in  8  source pixel column, 0..255.
REQ-008 PPU_PTR_Y  in  8  source scanline, 0..239.
REQ-009 STREAM_VALID  in  1  the data and pointers are valid this cycle.
REQ-010 CLR_ERR  in  1  clears UNDERRUN.
REQ-011 VGA_HS  out  1  horizontal sync, active-low.
REQ-012 VGA_VS  out  1  vertical sync, active-low.
REQ-013 VGA_DE  out  1  the visible 640x480 region is being driven.
REQ-014 VGA_COLOUR  out  6  output palette index.
REQ-015 VGA_X  out  10  output column, 0..H_TOTAL-1.
REQ-016 VGA_Y  out  10  output row, 0..V_TOTAL-1.
REQ-017 UNDERRUN  out  1  sticky flag: a required source line was not buffered.

Function
REQ-018 Write side: two 256x6 line banks (bank 0, bank 1); each bank has an 8-bit line tag and a tag-valid bit.
REQ-019 On STREAM_VALID with PPU_PTR_Y<240: write VGA_STREAM_DATA to bank PPU_PTR_Y[0] at address PPU_PTR_X.
REQ-020 A write to address 0 sets that bank's tag to PPU_PTR_Y and clears its tag-valid bit.
REQ-021 A write to address 255 sets that bank's tag-valid bit.
REQ-022 STREAM_VALID with PPU_PTR_Y>=240 is ignored; no state changes.
REQ-023 Timing counters h (0..H_TOTAL-1) and v (0..V_TOTAL-1) advance every clock.
REQ-024 h wraps to 0 after H_TOTAL-1, and v increments at that same clock.
REQ-025 v wraps to 0 after V_TOTAL-1, at the same clock as the h wrap.
REQ-026 Visible region: h<640 and v<480.
REQ-027 Image region: 64<=h<576 and v<480.
REQ-028 Source column = (h-64)>>1, so each source pixel is shown 2 clocks.
REQ-029 Source line = v>>1, so each source line is shown on 2 output lines.
REQ-030 Read bank = source line bit 0.
REQ-031 Image pixel is valid when the read bank tag equals the source line and its tag-valid bit is set.
REQ-032 A valid image pixel outputs the bank RAM data.
REQ-033 Visible pixels outside the image region, and invalid image pixels, output BORDER_COLOUR.
REQ-034 Outside the visible region VGA_COLOUR = 0.
REQ-035 Sync: HS low for 656<=h<=751; VS low for 490<=v<=491.
REQ-036 Latency: the RAM read is registered (1 cycle).
REQ-037 VGA_HS, VGA_VS, VGA_DE, VGA_X, VGA_Y and VGA_COLOUR are all registered and aligned; each reflects counter state (h,v) from exactly 2 clocks earlier.
REQ-038 UNDERRUN is set at the first image-region clock where the image pixel is invalid.
REQ-039 UNDERRUN remains set until CLR_ERR is sampled high.
REQ-040 If CLR_ERR and a new underrun occur in the same cycle, UNDERRUN ends set (set wins).
REQ-041 Simultaneous write and read of the same bank address: the read returns the old data (read-before-write).
REQ-042 The tag check uses the tag state before that cycle's update.

Reset
REQ-043 While RST_N is low: h=v=0, all tag-valid bits=0, UNDERRUN=0.
REQ-044 While RST_N is low, the outputs are VGA_HS=1, VGA_VS=1, VGA_DE=0, VGA_COLOUR=0, VGA_X=0, VGA_Y=0.
REQ-045 Line-bank RAM contents are not reset.
REQ-046 Reset asserted mid-frame aborts immediately; after release, counting restarts from h=0, v=0.
REQ-047 The first VGA outputs after reset release appear 2 clocks after release.

Verification
REQ-048 Reset release, no stream: VS low on output rows 490..491 and HS low for 96 clocks per line; image region shows 0x0F; UNDERRUN=1 at the first image clock (h=64, v=0).
REQ-049 Write line 0 with x=i, data=i[5:0], then line 1: output row 0 at h=64,65 shows 0; h=66,67 shows 1; rows 0 and 1 are identical; UNDERRUN stays 0.
REQ-050 Line 2 (bank 0) is written partially (x=0..100 only) before it is displayed: that line shows BORDER_COLOUR and UNDERRUN sets; CLR_ERR then clears it.
REQ-051 STREAM_VALID with PPU_PTR_Y=240 and data 0x2A: no bank or tag changes.
REQ-052 RST_N is pulsed low at h=300, v=100: outputs take their reset values asynchronously; after release, VGA_X=0 and VGA_Y=0 two clocks later.
REQ-053 CLR_ERR is asserted in the same cycle as a new underrun: UNDERRUN remains 1.
